fault_campaign_ctrl: RTL



---
 rtl/fault_campaign_pkg.sv | 41 ++++
 rtl/stim_lfsr.sv | 37 +++
 rtl/fault_campaign_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fault_campaign_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fault_campaign_pkg
// Description : Shared types and constants for the fault campaign controller:
//               FSM state encoding, idle fault-point value, stimulus LFSR
//               mask and the single-step LFSR helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fault_campaign_pkg;

  // Campaign controller states, explicitly encoded in 3 bits
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_DUT = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    REPORT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Widest fault-point bus supported; FP_IDLE is sliced down to FP_W
  localparam int unsigned FP_W_MAX = 32;

  // All-ones fault point lies outside every toggle range, so the DUT is fault-free
  localparam logic [FP_W_MAX-1:0] FP_IDLE = '1;

  // Galois feedback mask for the 8-bit stimulus LFSR
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  // One right-shift step of the Galois LFSR
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n = {1'b0, s[7:1]};
    if (s[0]) begin
      n = n ^ LFSR_MASK;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : stim_lfsr
// Description : 8-bit Galois LFSR producing the per-run stimulus bit. Reseeded
//               by load so every run sees the same sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module stim_lfsr
  import fault_campaign_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state,
  output logic       bit0
);

  logic [7:0] r_state;

  // Seed on reset or load, otherwise step once per advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= seed;
    end else if (load) begin
      r_state <= seed;
    end else if (advance) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign state = r_state;
  assign bit0  = r_state[0];

endmodule
`default_nettype wire

// File: rtl/fault_campaign_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fault_campaign_ctrl
// Description : Runs a hardware fault campaign: one golden run to capture the
//               reference signature, then one identically-stimulated run per
//               fault point, streaming a detected/undetected result for each.
// Revision    : 1.0 - initial release
// ============================================================================
module fault_campaign_ctrl
  import fault_campaign_pkg::*;
#(
  parameter int          FP_W       = 8,
  parameter int          DATA_W     = 8,
  parameter int          NUM_FP     = 1,
  parameter int          RUN_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED  = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              dut_reset,
  output logic              dut_enable,
  output logic [FP_W-1:0]   fp,
  input  logic [DATA_W-1:0] dut_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [FP_W-1:0]   result_fp,
  output logic              result_detected,
  output logic [DATA_W-1:0] golden_sig,
  output logic [FP_W-1:0]   detected_cnt,
  output logic              busy,
  output logic              done
);

  localparam int              CYC_W      = $clog2(RUN_CYCLES + 1);
  localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(RUN_CYCLES - 1);
  localparam logic [FP_W-1:0] c_fp_idle  = FP_IDLE[FP_W-1:0];
  localparam logic [FP_W-1:0] c_fp_last  = FP_W'((NUM_FP > 0) ? (NUM_FP - 1) : 0);
  localparam logic [FP_W-1:0] c_cnt_max  = '1;
  localparam bit              c_has_fp   = (NUM_FP > 0);

  state_t              r_state;
  state_t              w_state_next;
  logic [CYC_W-1:0]    r_cyc;
  logic [FP_W-1:0]     r_fp;
  logic                r_result_valid;
  logic [FP_W-1:0]     r_result_fp;
  logic                r_result_detected;
  logic [DATA_W-1:0]   r_golden_sig;
  logic [FP_W-1:0]     r_detected_cnt;

  logic                w_golden_pass;
  logic                w_mismatch;
  logic                w_lfsr_load;
  logic                w_lfsr_advance;
  logic [7:0]          w_lfsr_state;
  logic                w_lfsr_bit0;
  logic                w_unused_lfsr;

  // The golden pass is the only run with fp parked at the idle value
  assign w_golden_pass = (r_fp == c_fp_idle);
  assign w_mismatch    = (dut_out != r_golden_sig);
  assign w_unused_lfsr = ^w_lfsr_state;

  stim_lfsr u_stim_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (w_lfsr_load),
    .seed    (LFSR_SEED),
    .advance (w_lfsr_advance),
    .state   (w_lfsr_state),
    .bit0    (w_lfsr_bit0)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = RST_DUT;
        end
      end
      RST_DUT: w_state_next = RUN;
      RUN: begin
        if (r_cyc == c_cyc_last) begin
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!w_golden_pass) begin
          w_state_next = REPORT;
        end else if (c_has_fp) begin
          w_state_next = RST_DUT;
        end else begin
          w_state_next = DONE;
        end
      end
      REPORT: begin
        if (result_ready) begin
          w_state_next = (r_fp == c_fp_last) ? DONE : RST_DUT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State-decoded outputs and LFSR controls
  always_comb begin
    dut_reset      = 1'b1;
    dut_enable     = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    w_lfsr_load    = 1'b0;
    w_lfsr_advance = 1'b0;
    case (r_state)
      IDLE: busy = 1'b0;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      RST_DUT: w_lfsr_load = 1'b1;
      RUN: begin
        dut_reset      = 1'b0;
        dut_enable     = w_lfsr_bit0;
        w_lfsr_advance = 1'b1;
      end
      CAPTURE, REPORT: dut_reset = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  // Campaign datapath: run counter, fault point, signature and results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc             <= '0;
      r_fp              <= c_fp_idle;
      r_result_valid    <= 1'b0;
      r_result_fp       <= '0;
      r_result_detected <= 1'b0;
      r_golden_sig      <= '0;
      r_detected_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_fp           <= c_fp_idle;
            r_detected_cnt <= '0;
          end
        end
        RST_DUT: r_cyc <= '0;
        RUN:     r_cyc <= r_cyc + 1'b1;
        CAPTURE: begin
          if (w_golden_pass) begin
            r_golden_sig <= dut_out;
            if (c_has_fp) begin
              r_fp <= '0;
            end
          end else begin
            r_result_valid    <= 1'b1;
            r_result_fp       <= r_fp;
            r_result_detected <= w_mismatch;
            if (w_mismatch && (r_detected_cnt != c_cnt_max)) begin
              r_detected_cnt <= r_detected_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_fp           <= (r_fp == c_fp_last) ? c_fp_idle : (r_fp + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fp              = r_fp;
  assign result_valid    = r_result_valid;
  assign result_fp       = r_result_fp;
  assign result_detected = r_result_detected;
  assign golden_sig      = r_golden_sig;
  assign detected_cnt    = r_detected_cnt;

endmodule
`default_nettype wire
